fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// IF/ID pipeline register with stall, flush and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] inflight;
    logic [XLEN-1:0] hold_insn;
    logic [XLEN-1:0] hold_pc;
    logic            discard;
    logic            discard_nxt;

    logic            transfer;
    logic            take_inflight;
    logic            take_hold;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_load_insn;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath steering
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        discard_nxt    = discard;
        take_inflight  = 1'b0;
        take_hold      = 1'b0;
        ifid_load      = 1'b0;
        ifid_load_insn = imem_rdata;
        ifid_load_pc   = inflight;

        case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = redirect_target;
                end
                if (transfer) begin
                    // A request accepted alongside a redirect is already stale
                    take_inflight = 1'b1;
                    discard_nxt   = redirect;
                    state_nxt     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    pc_nxt = redirect_target;
                    if (imem_rvalid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_FETCH;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_FETCH;
                    end else if (stall) begin
                        take_hold = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_nxt    = inflight + PC_STEP;
                        state_nxt = S_FETCH;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_target;
                    state_nxt = S_FETCH;
                end else if (!stall) begin
                    ifid_load      = 1'b1;
                    ifid_load_insn = hold_insn;
                    ifid_load_pc   = hold_pc;
                    pc_nxt         = hold_pc + PC_STEP;
                    state_nxt      = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Memory-side outputs decoded from state; request is masked during reset
    always_comb begin
        imem_req  = (state == S_FETCH) && !rst;
        imem_addr = pc;
        transfer  = imem_req && imem_ready;
    end

    // PC, in-flight tracking and hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            inflight  <= '0;
            discard   <= 1'b0;
            hold_insn <= '0;
            hold_pc   <= '0;
        end else begin
            pc      <= pc_nxt;
            discard <= discard_nxt;
            if (take_inflight) begin
                inflight <= pc;
            end
            if (take_hold) begin
                hold_insn <= imem_rdata;
                hold_pc   <= inflight;
            end
        end
    end

    // IF/ID register; an empty slot always presents the NOP encoding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= NOP_INSN;
            pc_out      <= '0;
            valid       <= 1'b0;
        end else if (redirect || flush) begin
            instruction <= NOP_INSN;
            valid       <= 1'b0;
        end else if (ifid_load) begin
            instruction <= ifid_load_insn;
            pc_out      <= ifid_load_pc;
            valid       <= 1'b1;
        end else if (!stall) begin
            instruction <= NOP_INSN;
            valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait fetch, stall/hold,
// redirect discard, flush, async reset mid-request and PC wraparound.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;

    logic        rst2;
    logic        zero_in;
    logic [31:0] zero_pc;
    logic        req2;
    logic [31:0] addr2;
    logic        ready2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] insn2;
    logic [31:0] pc_out2;
    logic        valid2;

    int total;
    int bad;

    fetch_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_out      (pc_out),
        .valid       (valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst         (rst2),
        .stall       (zero_in),
        .flush       (zero_in),
        .redirect    (zero_in),
        .redirect_pc (zero_pc),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ready  (ready2),
        .imem_rvalid (rvalid2),
        .imem_rdata  (rdata2),
        .instruction (insn2),
        .pc_out      (pc_out2),
        .valid       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
        zero_in = 1'b0; zero_pc = '0;
        #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_insn got=%h exp=%h", instruction, NOP); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL req_after_reset got=%b exp=1", imem_req); end
    endtask

    // Zero-wait fetch from FETCH; leaves the stage back in FETCH at exp_pc+4
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] exp_pc);
        imem_ready = 1'b1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL f1_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL f1_addr got=%h exp=%h", imem_addr, exp_pc); end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL f1_wait_req got=%b exp=0", imem_req); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL f1_consumed got=%b exp=0", valid); end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL f1_valid got=%b exp=1", valid); end
        total++; if (instruction !== data) begin bad++; $display("FAIL f1_insn got=%h exp=%h", instruction, data); end
        total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL f1_pc_out got=%h exp=%h", pc_out, exp_pc); end
        total++; if (imem_addr !== exp_pc + 32'd4) begin bad++; $display("FAIL f1_next_addr got=%h exp=%h", imem_addr, exp_pc + 32'd4); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL f1_next_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_back_to_back();
        fetch_one(32'h0030_0093, 32'h0000_0000);
        fetch_one(32'h0040_0113, 32'h0000_0004);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        imem_ready = 1'b1;
        tick();
        total++; if (valid !== 1'b1 || instruction !== 32'h0040_0113) begin bad++; $display("FAIL stall_hold1 got=%b/%h exp=1/00400113", valid, instruction); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_8133;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instruction !== 32'h0040_0113 || pc_out !== 32'h4) begin bad++; $display("FAIL stall_hold2 got=%h@%h exp=00400113@4", instruction, pc_out); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold_req got=%b exp=0", imem_req); end
        stall = 1'b0;
        tick();
        total++; if (valid !== 1'b1 || instruction !== 32'h0020_8133) begin bad++; $display("FAIL stall_release got=%b/%h exp=1/00208133", valid, instruction); end
        total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL stall_pc_out got=%h exp=8", pc_out); end
        total++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin bad++; $display("FAIL stall_next got=%h/%b exp=c/1", imem_addr, imem_req); end
    endtask

    task automatic test_redirect();
        imem_ready = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        total++; if (imem_req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL redir_wait got=%b/%b exp=0/0", imem_req, valid); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL redir_drop got=%b/%h exp=0/%h", valid, instruction, NOP); end
        total++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin bad++; $display("FAIL redir_addr got=%h/%b exp=100/1", imem_addr, imem_req); end
        // Redirect coinciding with an accepted request
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_fetch_req got=%b exp=0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        total++; if (valid !== 1'b0 || imem_addr !== 32'h200) begin bad++; $display("FAIL redir_fetch_drop got=%b/%h exp=0/200", valid, imem_addr); end
    endtask

    task automatic test_flush();
        fetch_one(32'h0050_0293, 32'h0000_0200);
        imem_ready = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL flush got=%b/%h exp=0/%h", valid, instruction, NOP); end
        total++; if (imem_addr !== 32'h204 || imem_req !== 1'b1) begin bad++; $display("FAIL flush_pc got=%h/%b exp=204/1", imem_addr, imem_req); end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmw_in_wait got=%b exp=0", imem_req); end
        #2 rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rmw_async got=%b/%h exp=0/0", imem_req, imem_addr); end
        total++; if (valid !== 1'b0 || instruction !== NOP || pc_out !== 32'h0) begin bad++; $display("FAIL rmw_ifid got=%b/%h/%h exp=0/%h/0", valid, instruction, pc_out, NOP); end
        #1 rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        total++; if (valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL rmw_ignore got=%b/%h/%b exp=0/0/1", valid, imem_addr, imem_req); end
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        #1;
        total++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%b/%h exp=1/fffffffc", req2, addr2); end
        ready2 = 1'b1;
        tick();
        rvalid2 = 1'b1;
        rdata2  = 32'h0010_0093;
        tick();
        rvalid2 = 1'b0;
        total++; if (valid2 !== 1'b1 || pc_out2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", valid2, pc_out2); end
        total++; if (addr2 !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", addr2); end
        tick();
        rvalid2 = 1'b1;
        rdata2  = 32'h0020_0113;
        tick();
        rvalid2 = 1'b0;
        total++; if (insn2 !== 32'h0020_0113 || pc_out2 !== 32'h0 || addr2 !== 32'h4) begin bad++; $display("FAIL wrap_second got=%h@%h next=%h exp=00200113@0 next=4", insn2, pc_out2, addr2); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_mid_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
